// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP48A1 dot-product sequencer.
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    localparam logic [7:0] OPM_MUL_INIT   = 8'h01;
    localparam logic [7:0] OPM_MUL_ACC    = 8'h09;
    localparam int         OPM_PREADD_BIT = 4;
    localparam int         DEF_PIPE_LAT   = 3;

endpackage

// File: rtl/dsp_mac_tagpipe.sv
// Shift register that carries issue-slot tags alongside the DSP operand pipeline.
module dsp_mac_tagpipe
    import dsp_mac_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic RSTA,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [DEPTH-1:0] pipe_d;
    tag_t [DEPTH-1:0] pipe_q;

    always_comb begin
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge RSTA) begin
        if (RSTA) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer driving an external DSP48A1 slice as a multiply-accumulator.
// Define DSP_MAC_SEQ_PREADD_EN to add the D pre-adder path (product = (d+b)*a).
module dsp_mac_seq
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic             clk,
    input  logic             RSTA,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      a_in,
    input  logic [17:0]      b_in,
`ifdef DSP_MAC_SEQ_PREADD_EN
    input  logic [17:0]      d_in,
    output logic [17:0]      dsp_d,
`endif
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    input  logic [47:0]      dsp_p,
    output logic             busy,
    output logic             res_valid,
    output logic [47:0]      res_data
);

    state_t           state_d, state_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic [LEN_W-1:0] cnt_d, cnt_q;
    logic             in_ready_d, in_ready_q;
    logic             ce_d, ce_q;
    logic             busy_d, busy_q;
    logic             res_valid_d, res_valid_q;
    logic [47:0]      res_data_d, res_data_q;
    logic             last_done_d, last_done_q;

    logic handshake;
    tag_t issue_tag;
    tag_t aligned_tag;

    assign handshake = in_valid & in_ready_q;

    always_comb begin
        issue_tag.valid = handshake;
        issue_tag.first = handshake && (cnt_q == '0);
        issue_tag.last  = handshake && (cnt_q == len_q - LEN_W'(1));
    end

    // Tags reach the post-adder together with M, one cycle before P updates.
    dsp_mac_tagpipe #(
        .DEPTH(PIPE_LAT - 1)
    ) u_tagpipe (
        .clk    (clk),
        .RSTA   (RSTA),
        .tag_in (issue_tag),
        .tag_out(aligned_tag)
    );

    // High in the cycle after the last tag has been folded into P.
    assign last_done_d = aligned_tag.valid & aligned_tag.last;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (issue_tag.last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_done_q) begin
                    res_data_d  = dsp_p;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == RUN);
        ce_d       = (state_d == RUN) || (state_d == DRAIN);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge RSTA) begin
        if (RSTA) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            ce_q        <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            last_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            ce_q        <= ce_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            last_done_q <= last_done_d;
        end
    end

    // Bubbles feed zeros so they add M=0 while the pipeline keeps running.
    assign dsp_a = handshake ? a_in : '0;
    assign dsp_b = handshake ? b_in : '0;
`ifdef DSP_MAC_SEQ_PREADD_EN
    assign dsp_d = handshake ? d_in : '0;
`endif

    always_comb begin
        dsp_opmode = 8'h00;
        if (ce_q) begin
            dsp_opmode = (aligned_tag.valid && aligned_tag.first) ? OPM_MUL_INIT : OPM_MUL_ACC;
`ifdef DSP_MAC_SEQ_PREADD_EN
            dsp_opmode[OPM_PREADD_BIT] = 1'b1;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign dsp_ce    = ce_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Self-checking bench for dsp_mac_seq with a behavioural DSP48A1 model on the P side.
// Honours DSP_MAC_SEQ_PREADD_EN when defined.
module tb_dsp_mac_seq;

    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 3;
`ifdef DSP_MAC_SEQ_PREADD_EN
    localparam bit PREADD = 1'b1;
`else
    localparam bit PREADD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             RSTA;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      a_in, b_in;
    logic [17:0]      dsp_a, dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_ce;
    logic [47:0]      dsp_p;
    logic             busy, res_valid;
    logic [47:0]      res_data;
`ifdef DSP_MAC_SEQ_PREADD_EN
    logic [17:0]      d_in, dsp_d;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] op_a[$], op_b[$], op_d[$];
    int          gap[$];

    always #5 clk = ~clk;

    dsp_mac_seq #(
        .LEN_W   (LEN_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk       (clk),
        .RSTA      (RSTA),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef DSP_MAC_SEQ_PREADD_EN
        .d_in      (d_in),
        .dsp_d     (dsp_d),
`endif
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_opmode(dsp_opmode),
        .dsp_ce    (dsp_ce),
        .dsp_p     (dsp_p),
        .busy      (busy),
        .res_valid (res_valid),
        .res_data  (res_data)
    );

    // DSP48A1 slice with A1/B1/M/P registers, unregistered OPMODE, no reset.
    logic [17:0] m_a1, m_b1, b_pre;
    logic [35:0] m_m;
    logic [47:0] m_p;

    always_comb begin
        b_pre = dsp_b;
`ifdef DSP_MAC_SEQ_PREADD_EN
        if (dsp_opmode[4]) b_pre = dsp_d + dsp_b;
`endif
    end

    always_ff @(posedge clk) begin
        if (dsp_ce) begin
            m_a1 <= dsp_a;
            m_b1 <= b_pre;
            m_m  <= m_a1 * m_b1;
            m_p  <= ((dsp_opmode[3:2] == 2'b10) ? m_p : 48'd0) +
                    ((dsp_opmode[1:0] == 2'b01) ? {12'd0, m_m} : 48'd0);
        end
    end

    assign dsp_p = m_p;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Unsigned dot product of the queued pairs, modulo 2^48.
    function automatic logic [47:0] ref_dot();
        logic [63:0] acc;
        logic [17:0] bb;
        acc = 64'd0;
        for (int i = 0; i < op_a.size(); i++) begin
            bb = op_b[i];
            if (PREADD) bb = op_b[i] + op_d[i];
            acc = acc + 64'(op_a[i]) * 64'(bb);
        end
        return acc[47:0];
    endfunction

    task automatic clear_job();
        op_a.delete();
        op_b.delete();
        op_d.delete();
        gap.delete();
    endtask

    task automatic add_pair(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d, input int g);
        op_a.push_back(a);
        op_b.push_back(b);
        op_d.push_back(d);
        gap.push_back(g);
    endtask

    task automatic drive_operands(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d);
        a_in = a;
        b_in = b;
`ifdef DSP_MAC_SEQ_PREADD_EN
        d_in = d;
`else
        if (d == 18'h0) a_in = a;
`endif
    endtask

    // Runs one job from the current falling edge; gap[i] bubbles precede pair i.
    task automatic applyStimulus(input int n, input string name);
        int          idx;
        int          wait_cnt;
        int          cyc;
        int          last_cyc;
        bit          planned;
        logic [47:0] expected;
        logic [17:0] exp_a, exp_b;
        logic        ce_seen;
        idx      = 0;
        cyc      = 0;
        last_cyc = -1;
        expected = ref_dot();
        start    = 1'b1;
        len      = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            checkOutput({name, " res_valid"}, res_valid, 1);
            checkOutput({name, " res_data"}, res_data, 0);
            checkOutput({name, " busy"}, busy, 1);
            ce_seen = dsp_ce;
            @(negedge clk);
            ce_seen = ce_seen | dsp_ce;
            checkOutput({name, " dsp_ce quiet"}, ce_seen, 0);
            checkOutput({name, " res_valid one cycle"}, res_valid, 0);
            return;
        end
        wait_cnt = gap[0];
        while (cyc < 2000) begin
            if (res_valid) break;
            start   = 1'($urandom_range(0, 1));
            len     = LEN_W'($urandom);
            planned = (idx < n) && (wait_cnt == 0);
            if (planned) begin
                in_valid = 1'b1;
                drive_operands(op_a[idx], op_b[idx], op_d[idx]);
                exp_a = op_a[idx];
                exp_b = op_b[idx];
            end else begin
                in_valid = (idx >= n);
                drive_operands(18'($urandom), 18'($urandom), 18'($urandom));
                exp_a = 18'h0;
                exp_b = 18'h0;
            end
            #1;
            checkOutput({name, " in_ready"}, in_ready, (idx < n));
            checkOutput({name, " dsp_a"}, dsp_a, exp_a);
            checkOutput({name, " dsp_b"}, dsp_b, exp_b);
            checkOutput({name, " dsp_ce"}, dsp_ce, 1);
            checkOutput({name, " busy"}, busy, 1);
            checkOutput({name, " opmode sub/cin"}, {dsp_opmode[7], dsp_opmode[5]}, 0);
            checkOutput({name, " opmode preadd"}, dsp_opmode[4], PREADD);
            if (planned) begin
                last_cyc = cyc;
                idx++;
                wait_cnt = (idx < n) ? gap[idx] : 0;
            end else if (idx < n) begin
                wait_cnt--;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput({name, " res_valid seen"}, res_valid, 1);
        // res_valid rises PIPE_LAT edges after the edge that took the last pair.
        checkOutput({name, " latency"}, 64'(cyc - last_cyc), 64'(PIPE_LAT + 1));
        checkOutput({name, " res_data"}, res_data, expected);
        checkOutput({name, " done dsp_ce"}, dsp_ce, 0);
        @(negedge clk);
        checkOutput({name, " res_valid one cycle"}, res_valid, 0);
        checkOutput({name, " idle busy"}, busy, 0);
        checkOutput({name, " res_data held"}, res_data, expected);
    endtask

    initial begin
        logic [47:0] held;
        logic        saw_valid;
        int          n;

        RSTA     = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        drive_operands(18'h0, 18'h0, 18'h0);
        #1;
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset dsp_ce", dsp_ce, 0);
        checkOutput("reset dsp_opmode", dsp_opmode, 0);
        checkOutput("reset dsp_a", dsp_a, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset res_valid", res_valid, 0);
        checkOutput("reset res_data", res_data, 0);
        @(negedge clk);
        @(negedge clk);
        RSTA = 1'b0;
        @(negedge clk);

        clear_job();
        add_pair(18'd2, 18'd3, 18'd0, 0);
        add_pair(18'd4, 18'd5, 18'd0, 0);
        add_pair(18'd6, 18'd7, 18'd0, 0);
        if (!PREADD) checkOutput("ref back-to-back", ref_dot(), 48'd68);
        applyStimulus(3, "b2b");

        clear_job();
        add_pair(18'd2, 18'd3, 18'd0, 0);
        add_pair(18'd4, 18'd5, 18'd0, 2);
        add_pair(18'd6, 18'd7, 18'd0, 2);
        applyStimulus(3, "gaps");

        clear_job();
        applyStimulus(0, "len0");

        clear_job();
        add_pair(18'h3FFFF, 18'h3FFFF, 18'd0, 0);
        applyStimulus(1, "big");
        clear_job();
        add_pair(18'd1, 18'd1, 18'd0, 1);
        applyStimulus(1, "init");

        for (int j = 0; j < 6; j++) begin
            clear_job();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                add_pair(18'($urandom), 18'($urandom), 18'($urandom), $urandom_range(0, 2));
            end
            applyStimulus(n, "random");
        end

        clear_job();
        for (int i = 0; i < (2 ** LEN_W) - 1; i++) begin
            add_pair(18'($urandom), 18'($urandom), 18'($urandom), (i == 100) ? 1 : 0);
        end
        applyStimulus((2 ** LEN_W) - 1, "maxlen");

        // Abort a 4-pair job after two pairs with an asynchronous reset pulse.
        held     = res_data;
        start    = 1'b1;
        len      = LEN_W'(4);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        drive_operands(18'd11, 18'd12, 18'd1);
        @(negedge clk);
        drive_operands(18'd13, 18'd14, 18'd1);
        @(negedge clk);
        drive_operands(18'd15, 18'd16, 18'd1);
        #1;
        checkOutput("abort running", busy, 1);
        RSTA = 1'b1;
        #1;
        checkOutput("abort in_ready", in_ready, 0);
        checkOutput("abort dsp_ce", dsp_ce, 0);
        checkOutput("abort dsp_opmode", dsp_opmode, 0);
        checkOutput("abort dsp_a", dsp_a, 0);
        checkOutput("abort dsp_b", dsp_b, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort res_data", res_data, 0);
        checkOutput("abort prior result nonzero", (held != 48'd0), 1);
        @(negedge clk);
        RSTA      = 1'b0;
        in_valid  = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw_valid = saw_valid | res_valid;
        end
        checkOutput("abort no res_valid", saw_valid, 0);
        checkOutput("abort idle", busy, 0);
        clear_job();
        add_pair(18'd3, 18'd3, 18'd0, 0);
        applyStimulus(1, "after abort");
        checkOutput("after abort value", res_data, 48'd9);

`ifdef DSP_MAC_SEQ_PREADD_EN
        clear_job();
        add_pair(18'd2, 18'd3, 18'd4, 0);
        applyStimulus(1, "preadd");
        checkOutput("preadd value", res_data, 48'd14);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 SHALL have parameters:
- LEN_W, default 8: width of the product count.
- PIPE_LAT, default 3: cycles from operand issue to P update in the DSP48A1 slice (A1REG=B1REG=MREG=PREG=1, OPMODEREG=0).
REQ-002 SHALL have ports:
- clk  in  1  clock, rising edge.
- RSTA  in  1  asynchronous active-high reset.
- start  in  1  begin a dot-product job.
- len  in  LEN_W  number of products; sampled when start is accepted.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid and in_ready are both high.
- a_in  in  18  operand A.
- b_in  in  18  operand B.
- dsp_a  out  18  drives DSP A.
- dsp_b  out  18  drives DSP B.
- dsp_opmode  out  8  drives DSP OPMODE.
- dsp_ce  out  1  drives DSP CEA/CEB/CEM/CEP.
- dsp_p  in  48  DSP P output.
- busy  out  1  job in progress.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  48  accumulated result.

Function
REQ-003 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-004 IDLE: start=1 with len>0 SHALL latch len, clear the issue counter and go to RUN; start=1 with len=0 SHALL go to DONE with res_data=0.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 in_ready SHALL be high only in RUN.
REQ-007 On a handshake, dsp_a/dsp_b SHALL equal a_in/b_in and the issue counter SHALL increment.
REQ-008 In RUN without a handshake (a bubble), dsp_a and dsp_b SHALL be 0.
REQ-009 dsp_ce SHALL be 1 in RUN and DRAIN and 0 otherwise, so the DSP pipeline never stalls mid-job.
REQ-010 A tag (valid, first, last) SHALL accompany every issue slot and be delayed PIPE_LAT-1 cycles so it aligns with M at the post-adder.
REQ-011 The aligned tag SHALL select dsp_opmode:
- first: 8'h01 (X=M, Z=0).
- otherwise: 8'h09 (X=M, Z=P).
- bubble slots: 8'h09 while accumulating; they add M=0.
REQ-012 Bit 7 (subtract) and bit 5 (carry-in) of dsp_opmode SHALL always be 0.
REQ-013 Accepting the len-th pair SHALL move RUN to DRAIN.
REQ-014 DRAIN SHALL last until the last tag has passed the P register, i.e. exactly PIPE_LAT cycles after the last handshake; the FSM then goes to DONE.
REQ-015 DONE SHALL capture dsp_p into res_data, assert res_valid for one cycle and return to IDLE.
REQ-016 res_data SHALL hold its value until the next DONE.
REQ-017 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-018 Products SHALL be unsigned 18x18; accumulation SHALL be modulo 2^48 with no saturation.
REQ-019 len equal to 2^LEN_W-1 SHALL be supported without counter wrap.

Reset
REQ-020 RSTA SHALL asynchronously force:
- state IDLE, counters and tag pipe 0.
- in_ready=0, dsp_ce=0, dsp_opmode=0, dsp_a=dsp_b=0.
- busy=0, res_valid=0, res_data=0.
REQ-021 RSTA asserted mid-job SHALL abort the job with no res_valid; the next start SHALL run normally.

Configuration
REQ-022 Macro DSP_MAC_SEQ_PREADD_EN:
- Defined: adds port d_in (in, 18) and dsp_d (out, 18); dsp_d follows the dsp_a/dsp_b issue and bubble rules; dsp_opmode bit 4=1, so each product is (d_in+b_in)*a_in.
- Undefined: no d_in/dsp_d ports; dsp_opmode bit 4=0.

Structure
REQ-023 Package dsp_mac_pkg SHALL hold:
- the state enum.
- OPMODE constants OPM_MUL_INIT=8'h01, OPM_MUL_ACC=8'h09 and OPM_PREADD_BIT=4.
- the default PIPE_LAT.
REQ-024 The tag delay line SHALL be sub-module dsp_mac_tagpipe, parameterised by depth.

Verification
REQ-025 len=3, pairs (2,3),(4,5),(6,7) back-to-back -> single res_valid with res_data=68, 3 cycles after the last handshake.
REQ-026 len=3, same pairs with 2-cycle in_valid gaps -> res_data=68, and dsp_a=dsp_b=0 during the gaps.
REQ-027 len=0 -> res_valid the cycle after start with res_data=0 and no dsp_ce pulse.
REQ-028 Two jobs: job 1 pair (0x3FFFF,0x3FFFF), job 2 pair (1,1) -> job 2 res_data=1, proving OPM_MUL_INIT clears the prior accumulation.
REQ-029 RSTA pulse during RUN after 2 of 4 pairs -> all outputs 0 immediately and no res_valid; then len=1 with pair (3,3) -> res_data=9.
REQ-030 With DSP_MAC_SEQ_PREADD_EN, len=1, a=2, b=3, d=4 -> res_data=14.
